frame_stream_packetizer: RTL and testbench

- Sits directly upstream of the VGA output core. Accepts a raw 12-bit RGB444 pixel stream from the image-processing pipeline, with valid/ready and a start-of-frame marker.
- Enforces exactly H_RES*V_RES pixels per frame: pads short frames and discards overrun pixels.
- Buffers pixels in a small FIFO. Presents them to the VGA core's in_data/start_p/end_p/vga_ready stream port with SOP on the first pixel and EOP on the last pixel of each frame.

---
 rtl/frame_stream_packetizer.sv | 174 +++++++++++++++++
 tb/tb_frame_stream_packetizer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_packetizer.sv
// Frame-length enforcing packetizer in front of the VGA stream port.
// Pixels are tagged {eop,sop,data}, padded or trimmed to H_RES*V_RES, and buffered in a small FIFO.
module frame_stream_packetizer #(
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 480,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [11:0] PAD_COLOR  = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] pix_in,
    input  logic        pix_in_valid,
    input  logic        pix_in_sof,
    output logic        pix_in_ready,
    output logic [11:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_short,
    output logic        err_long,
    output logic [15:0] frame_count,
    output logic [1:0]  dbg_state
);
    localparam int              FRAME_PIX = H_RES * V_RES;
    localparam int              CW        = $clog2(FRAME_PIX);
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]   LAST_CNT  = CW'(FRAME_PIX - 1);
    localparam logic [AW:0]     FULL_LVL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {SEEK = 2'd0, STREAM = 2'd1, PAD = 2'd2} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_in_cnt;
    logic [13:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [15:0]   r_frame_count;
    logic          r_err_short;
    logic          r_err_long;

    logic          w_full;
    logic          w_empty;
    logic          w_short_det;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [11:0]   w_push_data;
    logic          w_push_sop;
    logic          w_push_eop;
    logic          w_set_short;
    logic          w_set_long;

    assign w_full      = (r_level == FULL_LVL);
    assign w_empty     = (r_level == '0);
    assign w_short_det = (r_state == STREAM) && pix_in_valid && pix_in_sof && (r_in_cnt != '0);

    // Both ports use plain valid/ready: a beat transfers on the rising edge where valid && ready.
    // A new sof arriving mid-frame is held off (ready low) until padding completes the frame.
    assign pix_in_ready = !reset && !w_full && !w_short_det &&
                          ((r_state == SEEK) || (r_state == STREAM));
    assign w_accept     = pix_in_valid && pix_in_ready;

    assign w_push_sop = (r_in_cnt == '0);
    assign w_push_eop = (r_in_cnt == LAST_CNT);

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_push_data  = pix_in;
        w_set_short  = 1'b0;
        w_set_long   = 1'b0;
        case (r_state)
            SEEK: begin
                if (w_accept && pix_in_sof) begin
                    w_push       = 1'b1;
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                if (w_short_det) begin
                    // The detection cycle already emits the first pad pixel.
                    w_set_short = 1'b1;
                    w_push_data = PAD_COLOR;
                    if (!w_full) begin
                        w_push       = 1'b1;
                        w_next_state = w_push_eop ? STREAM : PAD;
                    end else begin
                        w_next_state = PAD;
                    end
                end else if (w_accept) begin
                    if (pix_in_sof || (r_in_cnt != '0)) begin
                        w_push = 1'b1;
                    end else begin
                        w_set_long   = 1'b1;
                        w_next_state = SEEK;
                    end
                end
            end
            PAD: begin
                w_push_data = PAD_COLOR;
                if (!w_full) begin
                    w_push = 1'b1;
                    if (w_push_eop) begin
                        w_next_state = STREAM;
                    end
                end
            end
            default: w_next_state = SEEK;
        endcase
    end

    assign w_pop = !w_empty && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEEK;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_cnt    <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            r_err_short <= w_set_short;
            r_err_long  <= w_set_long;
            if (w_push) begin
                r_in_cnt <= w_push_eop ? '0 : r_in_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_push_eop, w_push_sop, w_push_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (r_mem[r_rd_ptr][13]) begin
                    r_frame_count <= r_frame_count + 16'd1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign {out_eop, out_sop, out_data} = r_mem[r_rd_ptr];
    assign out_valid   = !w_empty;
    assign err_short   = r_err_short;
    assign err_long    = r_err_long;
    assign frame_count = r_frame_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_frame_stream_packetizer.sv
// Directed bench for frame_stream_packetizer with an 8-pixel frame (4x2) and a 4-deep FIFO.
// Expected {eop,sop,data} beats are queued at stimulus time and popped by the output monitor.
module tb_frame_stream_packetizer;
    localparam logic [11:0] PADC = 12'hF0F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] pix_in = '0;
    logic        pix_in_valid = 1'b0;
    logic        pix_in_sof = 1'b0;
    logic        pix_in_ready;
    logic [11:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        err_short;
    logic        err_long;
    logic [15:0] frame_count;
    logic [1:0]  dbg_state;

    logic [13:0] exp_q[$];
    logic [13:0] mon_got;
    logic [13:0] mon_exp;
    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int n_short = 0;
    int n_long = 0;
    int base_short;
    int base_long;
    int base_acc;
    int stalls;

    frame_stream_packetizer #(
        .H_RES(4), .V_RES(2), .FIFO_DEPTH(4), .PAD_COLOR(PADC)
    ) dut (
        .clk(clk), .reset(reset),
        .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_sof(pix_in_sof),
        .pix_in_ready(pix_in_ready),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_valid(out_valid), .out_ready(out_ready),
        .err_short(err_short), .err_long(err_long),
        .frame_count(frame_count), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (err_short) n_short++;
            if (err_long) n_long++;
            if (out_valid && out_ready) begin
                mon_got = {out_eop, out_sop, out_data};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: got %h but nothing was expected", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL out_beat: got %h expected %h", mon_got, mon_exp);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic exp_beat(input logic [11:0] d, input logic sop, input logic eop);
        exp_q.push_back({eop, sop, d});
    endtask

    // driver: hold the pixel until the DUT shows ready, count refused cycles
    task automatic send(input logic [11:0] d, input logic sof, output int n_stall);
        int n;
        n = 0;
        n_stall = 0;
        pix_in = d;
        pix_in_sof = sof;
        pix_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (pix_in_ready) begin
                acc_cnt++;
                break;
            end
            n_stall++;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: pixel %h never accepted", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        pix_in_valid = 1'b0;
        pix_in_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] first);
        int s;
        for (int i = 0; i < 8; i++) begin
            exp_beat(first + 12'(i), (i == 0), (i == 7));
            send(first + 12'(i), (i == 0), s);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        base_short = n_short;
        base_long = n_long;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        check("rst_ready", pix_in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sop", out_sop, 0);
        check("rst_eop", out_eop, 0);
        check("rst_data", out_data, 0);
        check("rst_err_short", err_short, 0);
        check("rst_err_long", err_long, 0);
        check("rst_frame_count", frame_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("first_ready", pix_in_ready, 1);
        @(posedge clk);
        #1;

        // lock-on: three loose pixels are dropped, then a clean frame
        mark();
        send(12'h0E1, 1'b0, stalls);
        send(12'h0E2, 1'b0, stalls);
        send(12'h0E3, 1'b0, stalls);
        send_frame(12'h001);
        drain();
        check("lock_frame_count", frame_count, 1);
        check("lock_err_short", n_short - base_short, 0);
        check("lock_err_long", n_long - base_long, 0);

        // normal frame
        mark();
        send_frame(12'h001);
        drain();
        check("norm_frame_count", frame_count, 2);
        check("norm_err_short", n_short - base_short, 0);
        check("norm_err_long", n_long - base_long, 0);

        // short frame: five pixels, three pads, then the held sof pixel
        mark();
        for (int i = 1; i <= 5; i++) begin
            exp_beat(12'(i), (i == 1), 1'b0);
            send(12'(i), (i == 1), stalls);
        end
        exp_beat(PADC, 1'b0, 1'b0);
        exp_beat(PADC, 1'b0, 1'b0);
        exp_beat(PADC, 1'b0, 1'b1);
        exp_beat(12'h0A1, 1'b1, 1'b0);
        send(12'h0A1, 1'b1, stalls);
        check("short_pad_stalls", stalls, 3);
        for (int i = 2; i <= 8; i++) begin
            exp_beat(12'h0A0 + 12'(i), 1'b0, (i == 8));
            send(12'h0A0 + 12'(i), 1'b0, stalls);
        end
        drain();
        check("short_err_short", n_short - base_short, 1);
        check("short_err_long", n_long - base_long, 0);
        check("short_frame_count", frame_count, 4);

        // long frame: two extras after eop are discarded
        mark();
        send_frame(12'h101);
        send(12'h1F1, 1'b0, stalls);
        send(12'h1F2, 1'b0, stalls);
        send_frame(12'h201);
        drain();
        check("long_err_long", n_long - base_long, 1);
        check("long_err_short", n_short - base_short, 0);
        check("long_frame_count", frame_count, 6);

        // backpressure: FIFO fills after four pixels, then drains without loss
        out_ready = 1'b0;
        base_acc = acc_cnt;
        fork
            send_frame(12'h301);
            begin
                repeat (10) @(negedge clk);
                check("bp_accepted", acc_cnt - base_acc, 4);
                check("bp_ready_low", pix_in_ready, 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_frame_count", frame_count, 7);

        // async reset in the middle of a frame
        exp_beat(12'h001, 1'b1, 1'b0);
        exp_beat(12'h002, 1'b0, 1'b0);
        exp_beat(12'h003, 1'b0, 1'b0);
        send(12'h001, 1'b1, stalls);
        send(12'h002, 1'b0, stalls);
        send(12'h003, 1'b0, stalls);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", pix_in_ready, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_sop", out_sop, 0);
        check("mid_rst_eop", out_eop, 0);
        check("mid_rst_frame_count", frame_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_frame(12'h401);
        drain();
        check("post_rst_frame_count", frame_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
